// File: rtl/mem_island_rsp_buffer.sv
// Response buffer in front of a fixed-latency memory island port: tracks in-flight
// requests in a tag pipeline and returns ordered responses through a credit-protected FIFO.
module mem_island_rsp_buffer #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int Latency   = 1,
  parameter int Depth     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AddrWidth-1:0]       req_addr_i,
  input  logic                       req_write_i,
  input  logic [DataWidth-1:0]       req_data_i,
  input  logic [DataWidth/8-1:0]     req_strb_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DataWidth-1:0]       rsp_data_o,
  output logic                       rsp_write_o,
  output logic                       mem_q_valid_o,
  input  logic                       mem_q_ready_i,
  output logic [AddrWidth-1:0]       mem_q_addr_o,
  output logic                       mem_q_write_o,
  output logic [DataWidth-1:0]       mem_q_data_o,
  output logic [DataWidth/8-1:0]     mem_q_strb_o,
  input  logic [DataWidth-1:0]       mem_p_data_i,
  output logic [$clog2(Depth+1)-1:0] outstanding_o
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [CntW-1:0]                 outstanding_q, outstanding_d;
  logic [Latency-1:0]              vld_pipe_q, vld_pipe_d, wr_pipe_q, wr_pipe_d;
  logic [PtrW-1:0]                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [Depth-1:0][DataWidth-1:0] fifo_data_q, fifo_data_d;
  logic [Depth-1:0]                fifo_wr_q, fifo_wr_d;

  logic credit, hs_req, hs_rsp, push, push_wr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Request path is pure pass-through gated only by credit.
  assign credit        = (outstanding_q < CntW'(Depth));
  assign mem_q_valid_o = req_valid_i & credit;
  assign req_ready_o   = mem_q_ready_i & credit;
  assign mem_q_addr_o  = req_addr_i;
  assign mem_q_write_o = req_write_i;
  assign mem_q_data_o  = req_data_i;
  assign mem_q_strb_o  = req_strb_i;
  assign hs_req        = req_valid_i & req_ready_o;

  assign rsp_valid_o   = (cnt_q != '0);
  assign rsp_data_o    = fifo_data_q[rd_ptr_q];
  assign rsp_write_o   = fifo_wr_q[rd_ptr_q];
  assign hs_rsp        = rsp_valid_o & rsp_ready_i;
  assign outstanding_o = outstanding_q;

  assign push    = vld_pipe_q[Latency-1];
  assign push_wr = wr_pipe_q[Latency-1];

  always_comb begin
    vld_pipe_d    = '0;
    wr_pipe_d     = '0;
    vld_pipe_d[0] = hs_req;
    wr_pipe_d[0]  = req_write_i;
    for (int i = 1; i < Latency; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      wr_pipe_d[i]  = wr_pipe_q[i-1];
    end

    fifo_data_d = fifo_data_q;
    fifo_wr_d   = fifo_wr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = push_wr ? '0 : mem_p_data_i;
      fifo_wr_d[wr_ptr_q]   = push_wr;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (hs_rsp) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, hs_rsp})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({hs_req, hs_rsp})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      vld_pipe_q    <= '0;
      wr_pipe_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      fifo_data_q   <= '0;
      fifo_wr_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      vld_pipe_q    <= vld_pipe_d;
      wr_pipe_q     <= wr_pipe_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      fifo_data_q   <= fifo_data_d;
      fifo_wr_q     <= fifo_wr_d;
    end
  end

  a_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_q_valid_o && !mem_q_ready_i) ##1 mem_q_valid_o |->
      $stable({mem_q_addr_o, mem_q_write_o, mem_q_data_o, mem_q_strb_o}));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && cnt_q == CntW'(Depth)));
  a_out_range: assert property (@(posedge clk_i) disable iff (rst_i)
    !(hs_req && !hs_rsp && outstanding_q == CntW'(Depth)) &&
    !(hs_rsp && !hs_req && outstanding_q == '0));
endmodule

// File: tb/tb_mem_island_rsp_buffer.sv
// Directed bench for mem_island_rsp_buffer (Latency=2, Depth=4) with a small island model.
module tb_mem_island_rsp_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_data;
  logic        mq_valid, mq_ready, mq_write;
  logic [31:0] mq_addr, mq_data;
  logic [3:0]  mq_strb;
  logic [31:0] mp_data;
  logic [2:0]  outstanding;

  int checks = 0;
  int errors = 0;

  mem_island_rsp_buffer #(.AddrWidth(32), .DataWidth(32), .Latency(2), .Depth(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_data_i(req_data), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_write_o(rsp_write),
    .mem_q_valid_o(mq_valid), .mem_q_ready_i(mq_ready), .mem_q_addr_o(mq_addr),
    .mem_q_write_o(mq_write), .mem_q_data_o(mq_data), .mem_q_strb_o(mq_strb),
    .mem_p_data_i(mp_data), .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  // Island model: returns data_of(addr) two cycles after every grant (reads and writes alike).
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : a;
  endfunction

  logic [1:0]  isl_v = 2'b00;
  logic [31:0] isl_a0 = '0, isl_a1 = '0;
  always @(posedge clk) begin
    isl_v  <= {isl_v[0], req_valid & req_ready};
    isl_a0 <= req_addr;
    isl_a1 <= isl_a0;
  end
  assign mp_data = isl_v[1] ? data_of(isl_a1) : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h0; req_write = 1'b0;
    req_data = '0; req_strb = 4'h0; rsp_ready = 1'b0; mq_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (rsp_write !== 1'b0) begin errors++; $display("FAIL reset_rsp_write got %b exp 0", rsp_write); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (mq_valid !== 1'b1) begin errors++; $display("FAIL reset_mq_valid got %b exp 1", mq_valid); end
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h10; req_write = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_t1 got out=%0d v=%b exp out=1 v=0", outstanding, rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_t2_valid got %b exp 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_write !== 1'b0)
      begin errors++; $display("FAIL single_rsp got v=%b d=%h w=%b exp v=1 d=deadbeef w=0", rsp_valid, rsp_data, rsp_write); end
    tick();
    checks++; if (outstanding !== 3'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got out=%0d v=%b exp out=0 v=0", outstanding, rsp_valid); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8); req_addr = 32'(k + 1); req_write = 1'b0;
      #1;
      if (k < 8) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp 1", k, req_ready); end
      end
      if (k >= 3 && k <= 10) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'(k - 2))
          begin errors++; $display("FAIL b2b_rsp k=%0d got v=%b d=%h exp v=1 d=%h", k, rsp_valid, rsp_data, 32'(k - 2)); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle k=%0d got v=%b exp 0", k, rsp_valid); end
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; req_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_addr = (k < 4) ? 32'(32'h30 + k) : 32'h34;
      #1;
      checks++; if (req_ready !== (k < 4)) begin errors++; $display("FAIL bp_ready k=%0d got %b exp %b", k, req_ready, (k < 4)); end
      tick();
    end
    #1;
    checks++; if (outstanding !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_full got out=%0d rdy=%b exp out=4 rdy=0", outstanding, req_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h30) begin errors++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=30", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_credit got out=%0d rdy=%b exp out=3 rdy=1", outstanding, req_ready); end
    checks++; if (rsp_data !== 32'h31) begin errors++; $display("FAIL bp_head2 got %h exp 31", rsp_data); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_refull got out=%0d rdy=%b exp out=4 rdy=0", outstanding, req_ready); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'(32'h31 + k))
        begin errors++; $display("FAIL bp_drain k=%0d got v=%b d=%h exp v=1 d=%h", k, rsp_valid, rsp_data, 32'(32'h31 + k)); end
      tick();
    end
    #1;
    checks++; if (rsp_valid !== 1'b0 || outstanding !== 3'd0) begin errors++; $display("FAIL bp_empty got v=%b out=%0d exp v=0 out=0", rsp_valid, outstanding); end
  endtask

  task automatic test_island_stall();
    rsp_ready = 1'b1; mq_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h50; req_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 1'b0 || mq_valid !== 1'b1 || outstanding !== 3'd0)
        begin errors++; $display("FAIL stall k=%0d got rdy=%b qv=%b out=%0d exp rdy=0 qv=1 out=0", k, req_ready, mq_valid, outstanding); end
      tick();
    end
    mq_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL stall_out got %0d exp 1", outstanding); end
    tick(); tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h50) begin errors++; $display("FAIL stall_rsp got v=%b d=%h exp v=1 d=50", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_mixed();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b1; req_data = 32'hA5A5A5A5; req_strb = 4'hF;
    #1;
    checks++; if (mq_addr !== 32'h20 || mq_write !== 1'b1 || mq_data !== 32'hA5A5A5A5 || mq_strb !== 4'hF)
      begin errors++; $display("FAIL mixed_fwd got a=%h w=%b d=%h s=%h exp a=20 w=1 d=a5a5a5a5 s=f", mq_addr, mq_write, mq_data, mq_strb); end
    tick();
    req_addr = 32'h7; req_write = 1'b0; req_data = '0; req_strb = 4'h0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_data !== 32'h0)
      begin errors++; $display("FAIL mixed_wr got v=%b w=%b d=%h exp v=1 w=1 d=0", rsp_valid, rsp_write, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_data !== 32'h7)
      begin errors++; $display("FAIL mixed_rd got v=%b w=%b d=%h exp v=1 w=0 d=7", rsp_valid, rsp_write, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0; req_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 32'(32'h61 + k);
      tick();
    end
    req_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3 || rsp_valid !== 1'b1 || rsp_data !== 32'h61)
      begin errors++; $display("FAIL rmid_pre got out=%0d v=%b d=%h exp out=3 v=1 d=61", outstanding, rsp_valid, rsp_data); end
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || outstanding !== 3'd0)
      begin errors++; $display("FAIL rmid_async got v=%b out=%0d exp v=0 out=0", rsp_valid, outstanding); end
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || outstanding !== 3'd0)
        begin errors++; $display("FAIL rmid_post k=%0d got v=%b out=%0d exp v=0 out=0", k, rsp_valid, outstanding); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_island_stall();
    test_mixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_island_rsp_buffer.md
# mem_island_rsp_buffer

Latency-absorbing request/response buffer placed directly upstream of one narrow or wide port of the memory island core. The island port has a fixed access latency and no response backpressure. This block gives the requester a ready/valid response channel with backpressure. It tracks in-flight requests in a latency-matched pipeline, captures returning data into a credit-protected FIFO, and stalls new requests when no response slot is free. Responses are returned strictly in request order.

## Interface
Parameters:
- AddrWidth, 32, byte address width
- DataWidth, 32, data width; strobe width is DataWidth/8
- Latency, 1, cycles from request handshake to valid mem_p_data_i (>= 1)
- Depth, 4, maximum outstanding requests and response FIFO entries (>= 1; >= Latency+2 for full throughput)

Ports (clock and reset first):
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  requester request valid
- req_ready_o  out  1  request accepted when both high
- req_addr_i  in  AddrWidth  address
- req_write_i  in  1  1 = write, 0 = read
- req_data_i  in  DataWidth  write data
- req_strb_i  in  DataWidth/8  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  requester accepts response
- rsp_data_o  out  DataWidth  read data; 0 for writes
- rsp_write_o  out  1  response belongs to a write
- mem_q_valid_o  out  1  island request valid
- mem_q_ready_i  in  1  island grants request
- mem_q_addr_o, mem_q_write_o, mem_q_data_o, mem_q_strb_o  out  as req_*  forwarded request fields
- mem_p_data_i  in  DataWidth  island read data, valid exactly Latency cycles after grant
- outstanding_o  out  $clog2(Depth+1)  current outstanding count

## Operation
- Credit: `credit = (outstanding < Depth)`.
- Request path is combinational pass-through:
  - mem_q_valid_o = req_valid_i & credit
  - req_ready_o = mem_q_ready_i & credit
  - q fields are wired straight from req_*.
- Handshake `hs_req = req_valid_i & req_ready_o`.
- Tag pipeline: Latency stages of {valid, write}.
  - Stage 0 loads {hs_req, req_write_i} each cycle; stages shift every cycle, unconditionally.
  - When the last stage is valid in cycle c, the FIFO pushes {write ? 0 : mem_p_data_i, write} sampled in cycle c.
- FIFO: Depth entries with rd/wr pointers that wrap modulo Depth, plus a count.
  - Output is registered; there is no fall-through.
  - rsp_valid_o = (count != 0); the head drives rsp_data_o and rsp_write_o.
  - A push and a pop in the same cycle is legal; count stays unchanged.
- Outstanding counter: `hs_rsp = rsp_valid_o & rsp_ready_i`.
  - +1 on hs_req only, -1 on hs_rsp only, unchanged when both or neither occur.
  - Range is 0..Depth. The FIFO count plus in-flight tags is always equal to outstanding, so the FIFO can never overflow.
- Response ordering is strictly request order; responses are never dropped or duplicated outside reset.
- Reset (asynchronous, including mid-operation) clears:
  - the tag pipeline, FIFO pointers, FIFO count and outstanding counter;
  - in-flight transactions, which are discarded. mem_p_data_i returning after reset is ignored because the tags are cleared.
- Reset values of outputs:
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_write_o = 0, outstanding_o = 0.
  - req_ready_o = mem_q_ready_i and mem_q_valid_o = req_valid_i (credit = 1).
- Assertions:
  - mem_q_valid_o held while not granted implies stable q fields (inherited from the requester; the block does not register them).
  - Push into a full FIFO is illegal.
  - The outstanding counter never under- or overflows.

## Timing
- Request: zero-cycle pass-through; no added request latency.
- Read accepted in cycle t: mem_p_data_i is sampled in t+Latency, and rsp_valid_o rises in t+Latency+1.
- Minimum request-to-response latency is Latency+1 cycles.
- Throughput: one request per cycle sustained when rsp_ready_i = 1 and Depth >= Latency+2. Otherwise issue is limited to Depth requests per Latency+2 cycles.
- A pop in cycle c frees credit in cycle c+1 (registered counter). A request in c+1 may then be accepted.
- rsp_ready_i low: FIFO fills, outstanding reaches Depth, and req_ready_o drops the same cycle.

## Test plan
- Single read: Latency=2, Depth=4. Read addr 0x10 accepted at cycle 5, mem_p_data_i = 0xDEADBEEF at cycle 7 -> rsp_valid_o=1 at cycle 8, rsp_data_o=0xDEADBEEF, rsp_write_o=0, outstanding_o back to 0 at cycle 9.
- Back-to-back: Latency=2, Depth=4, rsp_ready_i=1, 8 consecutive reads returning data 1..8 -> req_ready_o never drops; responses 1..8 in order on 8 consecutive cycles.
- Backpressure: rsp_ready_i=0, continuous read requests -> exactly 4 accepted, req_ready_o=0 with outstanding_o=4. Raise rsp_ready_i for one cycle -> one pop, and one new request accepted the following cycle.
- Island stall: mem_q_ready_i=0 for 3 cycles while req_valid_i=1 -> req_ready_o=0, no tag inserted, outstanding_o unchanged; the request is accepted on the first cycle with ready.
- Mixed write/read: write 0xA5A5A5A5 with strb 0xF, then read -> first response has rsp_write_o=1 and data 0, second is read data; order is preserved.
- Reset mid-flight: 3 reads outstanding, assert rst_i for 1 cycle -> rsp_valid_o=0 and outstanding_o=0 immediately; later mem_p_data_i produces no response.
